// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic units (multiplier and divider).
// Latency: n/a (types and constants only). Backpressure: n/a.
// Holds default operand widths and the IDLE/RUN control state type.
package seq_arith_pkg;

    // Default widths: A side is multiplicand/quotient, B side is multiplier/divisor.
    localparam int SEQ_A_W = 32;
    localparam int SEQ_B_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // Width needed to count 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_multiplier_step.sv
// Combinational radix-2 shift-add cell: one multiply iteration.
// Latency: 0 cycles (pure combinational). Backpressure: none, evaluated every cycle.
// Accumulates the shifted multiplicand when the multiplier LSB is set, then shifts both.
module mul_step #(
    parameter int A_W = 32,
    parameter int B_W = 16
) (
    input  logic [A_W+B_W-1:0] acc,
    input  logic [A_W+B_W-1:0] a_sh,
    input  logic [B_W-1:0]     b_sh,
    output logic [A_W+B_W-1:0] acc_nxt,
    output logic [A_W+B_W-1:0] a_nxt,
    output logic [B_W-1:0]     b_nxt
);

    // a_sh is shifted at most B_W-1 times before its last use, so the full
    // A_W+B_W width never loses a significant bit.
    always_comb begin
        acc_nxt = b_sh[0] ? (acc + a_sh) : acc;
        a_nxt   = a_sh << 1;
        b_nxt   = b_sh >> 1;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential multiply-accumulate: product = a*b + c, one shift-add bit per RUN cycle.
// Latency: B_W+1 edges from acceptance; with SEQ_MUL_EARLY_TERM_EN, highest-set-bit(b)+2 (2 when b=0).
// Backpressure: start is sampled only while idle; requests during busy are dropped.
module seq_multiplier
    import seq_arith_pkg::*;
#(
    parameter int A_W = SEQ_A_W,
    parameter int B_W = SEQ_B_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [A_W-1:0]     multiplicand,
    input  logic [B_W-1:0]     multiplier,
    input  logic [B_W-1:0]     addend,
    output logic [A_W+B_W-1:0] product,
    output logic               ovf,
    output logic               busy,
    output logic               done
);

    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = cnt_width(B_W);

    seq_state_t        state_q;
    seq_state_t        state_d;

    logic [P_W-1:0]    acc_q;
    logic [P_W-1:0]    a_q;
    logic [B_W-1:0]    b_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_q;

    logic [P_W-1:0]    acc_nxt;
    logic [P_W-1:0]    a_nxt;
    logic [B_W-1:0]    b_nxt;

    logic              accept;
    logic              iterate;
    logic              finish;
    logic              last_iter;

    logic [P_W-1:0]    product_q;
    logic              ovf_q;
    logic              done_q;

    assign accept  = (state_q == IDLE) && start;
    assign iterate = (state_q == RUN) && !last_q;
    // Result is published one edge after the final iteration.
    assign finish  = (state_q == RUN) && last_q;

    mul_step #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_step (
        .acc     (acc_q),
        .a_sh    (a_q),
        .b_sh    (b_q),
        .acc_nxt (acc_nxt),
        .a_nxt   (a_nxt),
        .b_nxt   (b_nxt)
    );

`ifdef SEQ_MUL_EARLY_TERM_EN
    // No remaining multiplier bits means later iterations would add nothing.
    assign last_iter = (b_nxt == '0) || (cnt_q == CNT_W'(B_W - 1));
`else
    assign last_iter = (cnt_q == CNT_W'(B_W - 1));
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start)  state_d = RUN;
            RUN:  if (last_q) state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == RUN);
    end

    // Operand and accumulator datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else if (accept) begin
            acc_q  <= P_W'(addend);
            a_q    <= P_W'(multiplicand);
            b_q    <= multiplier;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else if (iterate) begin
            acc_q  <= acc_nxt;
            a_q    <= a_nxt;
            b_q    <= b_nxt;
            cnt_q  <= cnt_q + 1'b1;
            last_q <= last_iter;
        end
    end

    // Result registers change only on the completion edge, so they hold
    // until the next operation finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= finish;
            if (finish) begin
                product_q <= acc_q;
                ovf_q     <= |acc_q[P_W-1:A_W];
            end
        end
    end

    assign product = product_q;
    assign ovf     = ovf_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corner cases plus random operands
// against an arithmetic reference model (a*b+c, latency from multiplier bit positions).
module tb_seq_multiplier;

    localparam int A_W = 32;
    localparam int B_W = 16;
    localparam int P_W = A_W + B_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [A_W-1:0]     multiplicand = '0;
    logic [B_W-1:0]     multiplier = '0;
    logic [B_W-1:0]     addend = '0;
    logic [P_W-1:0]     product;
    logic               ovf;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cnt = 0;

    logic [63:0] exp_prod;
    logic        exp_ovf;
    int          exp_latency;

    seq_multiplier #(.A_W(A_W), .B_W(B_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .product      (product),
        .ovf          (ovf),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference latency: one edge per multiplier bit examined, plus the publish edge.
    function automatic int model_latency(input logic [B_W-1:0] b);
        int hi;
        hi = -1;
        for (int i = 0; i < B_W; i++) if (b[i]) hi = i;
`ifdef SEQ_MUL_EARLY_TERM_EN
        return (hi < 0) ? 2 : hi + 2;
`else
        return (hi >= B_W) ? 0 : B_W + 1;
`endif
    endfunction

    // Drives a request in the current cycle; returns just after the acceptance edge.
    task automatic launch(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input logic [B_W-1:0] c);
        multiplicand = a;
        multiplier   = b;
        addend       = c;
        start        = 1'b1;
        exp_prod     = 64'(a) * 64'(b) + 64'(c);
        exp_ovf      = (exp_prod >> A_W) != 0;
        exp_latency  = model_latency(b);
        @(posedge clk);
        #1;
        start   = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_finish(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " latency"}, 64'(cyc - acc_cyc), 64'(exp_latency));
        check({tag, " product"}, 64'(product), exp_prod);
        check({tag, " ovf"}, 64'(ovf), 64'(exp_ovf));
        check({tag, " busy"}, 64'(busy), 64'd0);
    endtask

    // After completion: done drops and the result stays put.
    task automatic check_hold(input string tag);
        repeat (3) @(posedge clk);
        #1;
        check({tag, " done pulse"}, 64'(done), 64'd0);
        check({tag, " hold"}, 64'(product), exp_prod);
    endtask

    task automatic run_op(input string tag, input logic [A_W-1:0] a,
                          input logic [B_W-1:0] b, input logic [B_W-1:0] c);
        @(negedge clk);
        launch(a, b, c);
        check({tag, " busy"}, 64'(busy), 64'd1);
        wait_finish(tag);
        check_hold(tag);
    endtask

    initial begin
        int d0;
        logic [A_W-1:0] ra;
        logic [B_W-1:0] rb;
        logic [B_W-1:0] rc;

        // Outputs under reset.
        #12;
        check("rst product", 64'(product), 64'd0);
        check("rst ovf", 64'(ovf), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op("basic", 32'h0000_1234, 16'h0010, 16'h0005);
        check("basic const", 64'(product), 64'h1_2345);
        run_op("max", 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF);
        check("max const", 64'(product), 64'hFFFF_0000_0000);
        run_op("div", 32'd100, 16'd7, 16'd2);
        run_op("bzero", 32'hDEAD_BEEF, 16'h0000, 16'h0042);
        run_op("bone", 32'h8000_0001, 16'h0001, 16'h0000);
        run_op("bmsb", 32'h0000_0003, 16'h8000, 16'h1111);

        // Start during RUN is ignored; only the first operation completes.
        @(negedge clk);
        d0 = done_cnt;
        launch(32'd3, 16'd3, 16'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        multiplicand = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_finish("ignore");
        check("ignore value", 64'(product), 64'd9);
        repeat (25) @(posedge clk);
        #1;
        check("ignore pulses", 64'(done_cnt - d0), 64'd1);

        // Start present in the done cycle is accepted straight away.
        @(negedge clk);
        launch(32'd11, 16'd13, 16'd1);
        wait_finish("b2b first");
        launch(32'h0001_0000, 16'h00FF, 16'h0003);
        check("b2b busy", 64'(busy), 64'd1);
        wait_finish("b2b second");
        check_hold("b2b second");

        // Asynchronous reset mid-operation abandons it.
        @(negedge clk);
        launch(32'h1234_5678, 16'hABCD, 16'h0007);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst busy", 64'(busy), 64'd0);
        check("arst done", 64'(done), 64'd0);
        check("arst product", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (25) @(posedge clk);
        #1;
        check("arst no done", 64'(done_cnt - d0), 64'd0);
        run_op("after rst", 32'h1234_5678, 16'hABCD, 16'h0007);

        // Random operands, mixing short and full-width multipliers.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            rc = 16'($urandom);
            run_op($sformatf("rand%0d", i), ra, rb, rc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
